uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 87, giving clock cycles per serial bit; legal range is 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port tx_byte, input, 8 bits: the byte to transmit; sampled only on handshake.
REQ-005 The block SHALL have port tx_valid, input, 1 bit: the upstream source has a byte on tx_byte.
REQ-006 The block SHALL have port tx_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-007 The block SHALL have port data_out, output, 1 bit: the serial line, idle high; it directly drives the data_in of uart_rx.
REQ-008 The block SHALL have port tx_done, output, 1 bit: a one-cycle pulse marking frame completion.

Function
REQ-009 The block SHALL implement an FSM with states IDLE, START, DATA and STOP, plus a bit-timer counter of width $clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-010 tx_ready SHALL be 1 only in IDLE; a handshake occurs on any cycle with tx_valid=1 and tx_ready=1.
REQ-011 On handshake the block SHALL capture tx_byte into an internal shift register and enter START on the next edge.
REQ-012 tx_byte changes after the handshake SHALL NOT affect the frame in progress.
REQ-013 While not in IDLE, tx_valid SHALL be ignored; the source holds its byte until tx_ready returns.
REQ-014 In START, data_out SHALL be 0 for exactly CLKS_PER_BIT cycles; the FSM then enters DATA with the bit index at 0.
REQ-015 In DATA, data_out SHALL present the captured bits LSB first, each for exactly CLKS_PER_BIT cycles.
REQ-016 After bit index 7 completes, the FSM SHALL enter STOP.
REQ-017 In STOP, data_out SHALL be 1 for exactly CLKS_PER_BIT cycles; the FSM then returns to IDLE.
REQ-018 In IDLE, data_out SHALL be 1.
REQ-019 data_out SHALL be driven from a register, so it is glitch-free; the first start-bit cycle is the cycle after the handshake.
REQ-020 tx_done SHALL be 1 for exactly one cycle: the first IDLE cycle after STOP. tx_ready is also 1 in that cycle.
REQ-021 One frame SHALL occupy 10*CLKS_PER_BIT cycles of data_out.
REQ-022 The minimum handshake-to-handshake period SHALL be 10*CLKS_PER_BIT+1 cycles, with the handshake taken in the tx_done cycle.
REQ-023 The bit timer SHALL count 0 to CLKS_PER_BIT-1 and then wrap to 0 on each bit boundary, with no drift across the frame.
REQ-024 There SHALL be no parity bit and exactly one stop bit (8N1).

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL set the state to IDLE, data_out=1, tx_ready=1, tx_done=0, and the timer, bit index and shift register to 0.
REQ-026 rst SHALL take priority over a handshake in the same cycle; the byte is not accepted.
REQ-027 If rst is asserted mid-frame, the frame SHALL be abandoned, data_out SHALL be 1 on the next edge, and no tx_done SHALL be issued.
REQ-028 After rst deasserts, the block SHALL accept a handshake on the first cycle.

Verification
REQ-029 The bench SHALL cover a single byte:
- Stimulus: CLKS_PER_BIT=87; send 0xA5.
- Response: data_out = 0,1,0,1,0,0,1,0,1,1, each level for 87 cycles, starting the cycle after the handshake.
- Response: tx_done pulses once, 870 cycles after the handshake edge.
REQ-030 The bench SHALL cover loopback:
- Stimulus: data_out wired to uart_rx data_in (same CLKS_PER_BIT); send 0x55, then 0x0F.
- Response: uart_rx raises recv_valid with byte_recv=0x55, then with byte_recv=0x0F.
REQ-031 The bench SHALL cover back-to-back transfers:
- Stimulus: tx_valid held at 1 with 0x00 then 0xFF.
- Response: second handshake in the tx_done cycle.
- Response: second start bit begins 871 cycles after the first.
- Response: exactly one idle-high cycle between the two frames.
REQ-032 The bench SHALL cover valid while busy:
- Stimulus: change tx_byte and pulse tx_valid during DATA.
- Response: tx_ready stays 0; the transmitted bits match the originally captured byte.
REQ-033 The bench SHALL cover reset mid-frame:
- Stimulus: assert rst for 1 cycle during DATA bit 3.
- Response: data_out=1 and tx_ready=1 on the next edge; no tx_done; the next send of 0x3C transmits correctly.
REQ-034 The bench SHALL cover a minimum divisor:
- Stimulus: CLKS_PER_BIT=2; send 0x81.
- Response: each bit lasts 2 cycles; frame length is 20 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte on a valid/ready handshake and shifts it
// out LSB first on a registered, idle-high serial line.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       data_out,
  output logic       tx_done
);

  localparam int unsigned TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [2:0]           bit_idx;
  logic [7:0]           shifter;
  logic                 bit_end;

  // Last cycle of the current serial bit; the timer wraps here so bit edges never drift.
  assign bit_end = (timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      data_out <= 1'b1;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shifter  <= tx_byte;
            timer    <= '0;
            data_out <= 1'b0;
            tx_ready <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            timer    <= '0;
            bit_idx  <= '0;
            data_out <= shifter[0];
            state    <= DATA;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              data_out <= 1'b1;
              state    <= STOP;
            end else begin
              // Next data bit comes from the shifter before it is shifted down.
              bit_idx  <= bit_idx + 3'd1;
              shifter  <= {1'b0, shifter[7:1]};
              data_out <= shifter[1];
            end
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            timer    <= '0;
            tx_ready <= 1'b1;
            tx_done  <= 1'b1;
            state    <= IDLE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          data_out <= 1'b1;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: per-cycle line checks plus a serial receiver model
// that decodes the line and scores each byte against a queue filled at handshake.
module tb_uart_tx;

  localparam int N1 = 87;
  localparam int N2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic tx_valid = 1'b0;
  logic sel = 1'b0;

  logic valid1, valid2, ready1, ready2, line1, line2, done1, done2;
  logic line, ready, done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int rx_count = 0;

  logic [7:0] sb[$];

  logic       mon_busy = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign valid1 = tx_valid & ~sel;
  assign valid2 = tx_valid & sel;
  assign line   = sel ? line2 : line1;
  assign ready  = sel ? ready2 : ready1;
  assign done   = sel ? done2 : done1;

  uart_tx #(.CLKS_PER_BIT(N1)) dut1 (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_valid(valid1),
    .tx_ready(ready1), .data_out(line1), .tx_done(done1)
  );

  uart_tx #(.CLKS_PER_BIT(N2)) dut2 (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_valid(valid2),
    .tx_ready(ready2), .data_out(line2), .tx_done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a byte and wait for the handshake edge; returns just after that edge.
  task automatic send(input logic [7:0] b, input bit hold);
    int w;
    w = 0;
    @(negedge clk);
    tx_byte  = b;
    tx_valid = 1'b1;
    while (ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("send_ready", ready, 1);
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    if (!sel) sb.push_back(b);
    if (!hold) tx_valid = 1'b0;
  endtask

  // Check every cycle of a frame starting the cycle after the handshake,
  // finishing on the tx_done cycle.
  task automatic check_frame(input logic [7:0] b, input int n, input bit meddle);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * n; k++) begin
      @(negedge clk);
      if (meddle && k == 3 * n) begin
        tx_byte  = ~b;
        tx_valid = 1'b1;
      end
      if (meddle && k == 3 * n + 4) tx_valid = 1'b0;
      chk("line", line, 32'(bits[k / n]));
      chk("ready_busy", ready, 0);
      chk("done_busy", done, 0);
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("ready_done", ready, 1);
    chk("line_idle", line, 1);
    chk("done_latency", cyc - hs_cyc, 10 * n);
  endtask

  // Receiver model on dut1's line: samples mid-bit, scores against the queue.
  always @(negedge clk) begin
    if (rst) begin
      mon_busy <= 1'b0;
      mon_cnt  <= 0;
      sb.delete();
    end else if (!mon_busy) begin
      if (line1 === 1'b0) begin
        mon_busy <= 1'b1;
        mon_cnt  <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt == N1 / 2) begin
        chk("rx_start", line1, 0);
      end else if (mon_cnt > N1 && mon_cnt < 9 * N1 && (mon_cnt % N1) == N1 / 2) begin
        mon_byte[3'(mon_cnt / N1 - 1)] <= line1;
      end else if (mon_cnt == 9 * N1 + N1 / 2) begin
        chk("rx_stop", line1, 1);
        chk("rx_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) chk("rx_byte", mon_byte, sb.pop_front());
        rx_count <= rx_count + 1;
        mon_busy <= 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h1;
    int rel;
    int dcount;
    logic [9:0] bits;

    // Reset state for both instances
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_line1", line1, 1);
    chk("rst_ready1", ready1, 1);
    chk("rst_done1", done1, 0);
    chk("rst_line2", line2, 1);
    chk("rst_ready2", ready2, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single byte 0xA5
    send(8'hA5, 1'b0);
    check_frame(8'hA5, N1, 1'b0);
    @(negedge clk);
    chk("done_single", done1, 0);

    // Loopback through the receiver model
    send(8'h55, 1'b0);
    check_frame(8'h55, N1, 1'b0);
    send(8'h0F, 1'b0);
    check_frame(8'h0F, N1, 1'b0);

    // Back-to-back with tx_valid held high
    send(8'h00, 1'b1);
    h1 = hs_cyc;
    tx_byte = 8'hFF;
    check_frame(8'h00, N1, 1'b0);
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    sb.push_back(8'hFF);
    tx_valid = 1'b0;
    chk("b2b_period", hs_cyc - h1, 10 * N1 + 1);
    check_frame(8'hFF, N1, 1'b0);

    // Valid and byte change while busy
    send(8'hC3, 1'b0);
    check_frame(8'hC3, N1, 1'b1);

    // Reset during data bit 3
    send(8'h96, 1'b0);
    bits = {1'b1, 8'h96, 1'b0};
    for (int k = 0; k < 4 * N1 + 10; k++) begin
      @(negedge clk);
      chk("abort_pre_line", line1, 32'(bits[k / N1]));
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_line", line1, 1);
    chk("abort_ready", ready1, 1);
    chk("abort_done", done1, 0);
    dcount = 0;
    repeat (900) begin
      @(negedge clk);
      if (done1 === 1'b1) dcount++;
    end
    chk("abort_no_done", dcount, 0);

    // Reset beats a handshake in the same cycle; first cycle after release accepts
    @(posedge clk);
    #1;
    rst = 1'b1;
    tx_byte = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rel = cyc;
    chk("prio_line", line1, 1);
    chk("prio_ready", ready1, 1);
    send(8'h3C, 1'b0);
    chk("first_cycle_accept", hs_cyc - rel, 1);
    check_frame(8'h3C, N1, 1'b0);

    // Minimum divisor instance
    sel = 1'b1;
    send(8'h81, 1'b0);
    check_frame(8'h81, N2, 1'b0);
    sel = 1'b0;

    repeat (10) @(negedge clk);
    chk("rx_count", rx_count, 7);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
